muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
//  Consumes RS1/RS2 operand data and produces one write-back (rd, data, wr_en) for the
//  register-file write port. Multi-cycle with busy/done handshake so the core stalls while busy.
// PARAMETERS
//  XLEN  32  operand/result width; the iteration counter covers XLEN steps
// PORTS
//  clk            in   1     single clock; all state updates on posedge
//  rst            in   1     asynchronous, active-high reset
//  start_i        in   1     launch an op; accepted only when busy_o=0
//  flush_i        in   1     abort the in-flight op (pipeline flush/trap)
//  funct3_i       in   3     RV32M op: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1_data_i     in   XLEN  operand A (dividend / multiplicand)
//  rs2_data_i     in   XLEN  operand B (divisor / multiplier)
//  rd_addr_i      in   5     destination register
//  busy_o         out  1     op in flight (start seen, done not yet pulsed)
//  done_o         out  1     one-cycle pulse; result_o/rd_addr_o valid this cycle
//  result_o       out  XLEN  result; holds last value until the next done
//  rd_addr_o      out  5     destination of result
//  wr_en_o        out  1     =done_o && (rd_addr_o!=0); drives register-file write enable
// BEHAVIOUR
//  Reset: state IDLE; busy_o=0, done_o=0, wr_en_o=0, result_o=0, rd_addr_o=0; counter=0.
//  FSM: IDLE -> CALC (start_i, normal op) | DONE (start_i, special case)
//       CALC -> FIX after XLEN iterations; FIX -> DONE; DONE -> IDLE (done_o=1 for 1 cycle).
//  Latency: normal ops pulse done_o XLEN+2 cycles after the start cycle (34 @XLEN=32);
//   special cases pulse done_o on the cycle after start.
//  busy_o=1 in CALC/FIX/DONE-pending; done_o asserted only in DONE; busy_o=0 during DONE.
//  Start cycle latches funct3, rd, and operand magnitudes: signed ops take |x| per signedness
//   (MULH: both signed; MULHSU: rs1 signed, rs2 unsigned; DIV/REM: both signed).
//  MUL family: radix-2 shift-add over 2*XLEN product; MUL returns low XLEN,
//   MULH/MULHSU/MULHU return high XLEN after sign fix.
//  DIV family: radix-2 restoring division on magnitudes, one quotient bit per cycle.
//  FIX: negate product if operand signs differ (signed ops); negate quotient if dividend sign
//   != divisor sign; remainder takes dividend sign. Full 2*XLEN-bit two's-complement negate.
//  Special cases (no iteration, start -> DONE):
//   divisor=0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//   signed overflow (rs1=0x80000000, rs2=-1): DIV -> 0x80000000; REM -> 0.
//  start_i while busy_o=1: ignored, no effect on in-flight op.
//  flush_i: any state -> IDLE next cycle; no done_o/wr_en_o for the aborted op; result_o held.
//  flush_i and start_i in the same cycle: flush wins, start dropped.
//  flush_i in DONE cycle: done already pulsing is NOT suppressed (write completes).
//  rd_addr_i=0: op executes normally; done_o pulses; wr_en_o stays 0.
//  Reset mid-op: immediate return to reset values; no write-back.
// STRUCTURE
//  Shared package rv32m_pkg: funct3 op enum (MUL..REMU), FSM state enum
//   (IDLE, CALC, FIX, DONE), XLEN default constant.
//  Single module, no sub-module; the shift-add/restoring datapath shares one 2*XLEN
//   accumulator and an XLEN operand register.
// TESTING
//  MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, done_o at start+34, wr_en_o=1 for rd=5.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0; MULHSU -1*2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIVU 0x1234/0 -> 0xFFFFFFFF, REMU -> 0x1234, DIV 0x80000000/-1 -> 0x80000000,
//   REM -> 0; each done_o at start+1.
//  flush_i at start+10 -> IDLE, no done_o; new start at start+12 completes normally;
//   start_i pulsed at start+5 while busy -> ignored, original result returned.
//  rst asserted at start+20 -> all outputs 0 asynchronously; rd_addr_i=0 op -> done_o=1,
//   wr_en_o=0.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 op encoding, multiply/divide FSM states and the default width.
package rv32m_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// sharing one 2*XLEN accumulator, with busy/done handshake and register-file write-back.
module muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            wr_en_o
);

  localparam int unsigned CW = $clog2(XLEN);

  state_e            state, state_nxt;
  op_e               op_q, op_in;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     cnt;
  logic [4:0]        rd_q;
  logic              div_q, neg_q, rem_neg_q;

  logic              accept, is_div, a_signed, b_signed, sa, sb;
  logic              div_zero, ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign busy_o  = (state == CALC) || (state == FIX);
  assign done_o  = (state == DONE);
  assign wr_en_o = done_o && (rd_addr_o != '0);
  assign accept  = start_i && !busy_o && !flush_i;

  // Operand decode on the start cycle
  always_comb begin
    op_in    = op_e'(funct3_i);
    is_div   = funct3_i[2];
    a_signed = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_in inside {OP_MULH, OP_DIV, OP_REM};
    sa       = a_signed && rs1_data_i[XLEN-1];
    sb       = b_signed && rs2_data_i[XLEN-1];
    mag_a    = sa ? -rs1_data_i : rs1_data_i;
    mag_b    = sb ? -rs2_data_i : rs2_data_i;
    div_zero = is_div && (rs2_data_i == '0);
    ovf      = (op_in inside {OP_DIV, OP_REM}) && (rs2_data_i == '1)
               && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}});
    special  = div_zero || ovf;
    if (div_zero) special_res = funct3_i[1] ? rs1_data_i : '1;
    else          special_res = funct3_i[1] ? '0 : rs1_data_i;
  end

  // One iteration of each algorithm; acc holds {hi, lo}
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, opnd};
    div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo      = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                        fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = neg_q ? -quo : quo;
      default:                       fix_res = rem_neg_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = IDLE;
      CALC: if (cnt == CW'(XLEN-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
    endcase
    // A start is only possible when not busy, i.e. from IDLE or DONE
    if (accept)  state_nxt = special ? DONE : CALC;
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      opnd      <= '0;
      cnt       <= '0;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      rd_q      <= rd_addr_i;
      div_q     <= is_div;
      neg_q     <= sa ^ sb;
      rem_neg_q <= sa;
      cnt       <= '0;
      if (special) begin
        result_o  <= special_res;
        rd_addr_o <= rd_addr_i;
      end else begin
        acc  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
        opnd <= is_div ? mag_b : mag_a;
      end
    end else if (!flush_i && state == CALC) begin
      acc <= div_q ? div_next : mul_next;
      cnt <= cnt + 1'b1;
    end else if (!flush_i && state == FIX) begin
      result_o  <= fix_res;
      rd_addr_o <= rd_q;
    end
  end

endmodule
